// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared constants and FSM state type for the L2 port arbiter
package l2_arb_pkg;

  localparam int NREQ             = 8;
  localparam int ID_W             = 3;
  localparam int HOLD_MAX_DEFAULT = 64;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_prio_encoder.sv
// rtl/rr_prio_encoder.sv - combinational round-robin find: rotate by ptr, pick lowest, un-rotate
module rr_prio_encoder
  import l2_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] win_id,
  output logic [NREQ-1:0] win_onehot
);

  logic [NREQ-1:0] rot;
  logic [ID_W-1:0] rot_idx;
  logic [ID_W-1:0] src_idx;

  always_comb begin
    rot     = '0;
    src_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      src_idx = ID_W'(i) + ptr;
      rot[i]  = req[src_idx];
    end
  end

  // Scanning downward leaves the lowest set rotated bit, i.e. the first one at or after ptr.
  always_comb begin
    rot_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) rot_idx = ID_W'(i);
    end
  end

  always_comb begin
    any        = |req;
    win_id     = rot_idx + ptr;
    win_onehot = '0;
    if (any) win_onehot[win_id] = 1'b1;
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - round-robin owner of the single L2 access port; L2_ARB_TIMEOUT_EN adds forced revocation
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_valid,
  output logic            timeout_err
);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            valid_q, valid_d;

  logic            enc_any;
  logic [ID_W-1:0] enc_id;
  logic [NREQ-1:0] enc_onehot;

  logic            holder_done;
  logic            holder_req;
  logic            tmo;

  rr_prio_encoder u_enc (
    .req        (req),
    .ptr        (ptr_q),
    .any        (enc_any),
    .win_id     (enc_id),
    .win_onehot (enc_onehot)
  );

  assign holder_done = done[id_q];
  assign holder_req  = req[id_q];

`ifdef L2_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX);

  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              terr_q;

  // Abandonment or done in the limit cycle is an ordinary release, not a revocation.
  assign tmo = (state_q == ARB_GRANT) && (cnt_q == HOLD_W'(HOLD_MAX - 1))
               && !holder_done && holder_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= tmo;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB_IDLE) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  assign timeout_err = terr_q;
`else
  logic unused_hold_max;

  assign unused_hold_max = (HOLD_MAX > 0);
  assign tmo             = 1'b0;
  assign timeout_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    id_d    = id_q;
    valid_d = valid_q;
    case (state_q)
      ARB_IDLE: begin
        if (enc_any) begin
          state_d = ARB_GRANT;
          grant_d = enc_onehot;
          id_d    = enc_id;
          valid_d = 1'b1;
        end
      end
      ARB_GRANT: begin
        // No preemption: only the holder's own done/req (or the timeout) ends the grant.
        if (holder_done || !holder_req || tmo) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = id_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - directed self-checking bench for l2_port_arbiter
module tb_l2_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  l2_port_arbiter #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h00);
    check({tag, "_valid"}, 32'(grant_valid), 32'h0);
    check({tag, "_terr"}, 32'(timeout_err), 32'h0);
  endtask

  task automatic check_grant(input string tag, input logic [2:0] id);
    logic [7:0] oh;
    oh = 8'h01 << id;
    check({tag, "_grant"}, 32'(grant), 32'(oh));
    check({tag, "_id"}, 32'(grant_id), 32'(id));
    check({tag, "_valid"}, 32'(grant_valid), 32'h1);
  endtask

  initial begin
    logic [7:0] oh;
    logic       held_ok;

    rst  = 1'b1;
    req  = 8'h00;
    done = 8'h00;
    step();
    step();
    check_idle("reset");
    check("reset_ptr", 32'(dut.ptr_q), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("no_req");
    end

    req = 8'h14;
    step();
    check_grant("req14_first", 3'd2);
    done = 8'h04;
    step();
    check_idle("req14_release");
    done = 8'h00;
    req  = 8'h10;
    step();
    check_grant("req14_second", 3'd4);
    done = 8'h10;
    step();
    check_idle("req14_release2");
    check("req14_ptr", 32'(dut.ptr_q), 32'h5);
    done = 8'h00;
    req  = 8'h00;
    step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      check_grant($sformatf("rr_%0d", k), 3'(k % 8));
      oh   = 8'h01 << (k % 8);
      done = oh;
      step();
      check_idle($sformatf("rr_gap_%0d", k));
      done = 8'h00;
    end
    req = 8'h00;
    step();

    req = 8'h08;
    step();
    check_grant("h3_grant", 3'd3);
    done = 8'h20;
    step();
    check_grant("h3_nonholder_done", 3'd3);
    done = 8'h08;
    req  = 8'h0A;
    step();
    check_idle("h3_done_wins");
    done = 8'h00;
    req  = 8'h02;
    step();
    check_grant("h1_after_h3", 3'd1);
    done = 8'h02;
    step();
    check_idle("h1_release");
    done = 8'h00;
    req  = 8'h00;
    step();

    req = 8'h01;
    step();
    check_grant("hold_entry", 3'd0);
`ifdef L2_ARB_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      step();
      check_grant($sformatf("hold_cnt_%0d", c + 1), 3'd0);
      check("hold_terr_low", 32'(timeout_err), 32'h0);
    end
    step();
    check("tmo_grant", 32'(grant), 32'h00);
    check("tmo_valid", 32'(grant_valid), 32'h0);
    check("tmo_terr", 32'(timeout_err), 32'h1);
    req = 8'h00;
    step();
    check_idle("tmo_after");
`else
    held_ok = 1'b1;
    for (int c = 0; c < 110; c++) begin
      step();
      if (grant !== 8'h01 || grant_valid !== 1'b1 || timeout_err !== 1'b0) held_ok = 1'b0;
    end
    check("hold_110_cycles", 32'(held_ok), 32'h1);
    req = 8'h00;
    step();
    check_idle("hold_abandon");
`endif
    step();

    req = 8'h40;
    step();
    check_grant("g6_grant", 3'd6);
    rst = 1'b1;
    step();
    check_idle("rst_mid_grant");
    check("rst_mid_ptr", 32'(dut.ptr_q), 32'h0);
    rst = 1'b0;
    req = 8'hFF;
    step();
    check_grant("after_rst_from_ptr0", 3'd0);
    req = 8'h00;
    step();
    check_idle("final_abandon");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
